stream_xbar_demux: RTL and testbench

Return-path block for `stream_xbar`: it takes one crossbar output stream (data/id/last/valid/ready) and steers each packet back to one of `S_DATA_COUNT` per-source output streams, selected by the `id` field. Input is buffered by a 2-entry skid buffer, so handshakes are fully registered at full throughput. The routing id is locked for the whole packet. Beats whose id changes mid-packet are dropped and flagged. One instance sits on each crossbar master port whose traffic must be returned to its originating source.

---
 rtl/stream_xbar_demux_pkg.sv | 5 +
 rtl/stream_xbar_demux_if.sv | 27 ++
 rtl/stream_xbar_demux_skid_buf.sv | 52 +++++
 rtl/stream_xbar_demux.sv | 75 +++++++
 tb/tb_stream_xbar_demux.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_xbar_demux_pkg.sv
// stream_xbar_demux_pkg: shared types and constants for the crossbar return-path demux.
package stream_xbar_pkg;
    typedef enum logic {IDLE, PKT} demux_state_t;
    localparam int DROP_CNT_WIDTH = 8;
endpackage

// File: rtl/stream_xbar_demux_if.sv
// stream_xbar_demux_if: input stream, per-source output streams and status of the return-path demux.
interface stream_xbar_demux_if #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2
);
    import stream_xbar_pkg::*;
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);
    logic [T_DATA_WIDTH-1:0]   s_data_i;
    logic [T_ID___WIDTH-1:0]   s_id_i;
    logic                      s_last_i;
    logic                      s_valid_i;
    logic                      s_ready_o;
    logic [T_DATA_WIDTH-1:0]   m_data_o [S_DATA_COUNT];
    logic [S_DATA_COUNT-1:0]   m_last_o;
    logic [S_DATA_COUNT-1:0]   m_valid_o;
    logic [S_DATA_COUNT-1:0]   m_ready_i;
    logic                      err_o;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_o;
    modport slave (
        input  s_data_i, s_id_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_last_o, m_valid_o, err_o, drop_cnt_o
    );
    modport master (
        output s_data_i, s_id_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_last_o, m_valid_o, err_o, drop_cnt_o
    );
endinterface

// File: rtl/stream_xbar_demux_skid_buf.sv
// stream_skid_buf: 2-entry skid buffer (head + spare) with a registered ready.
module stream_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_pop
);
    logic [W-1:0] h_data_q, h_data_d, s_data_q, s_data_d;
    logic         h_valid_q, h_valid_d, s_valid_q, s_valid_d, ready_q, accept;
    always_comb begin
        accept    = in_valid && ready_q;
        h_valid_d = h_valid_q;
        h_data_d  = h_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (out_pop) begin
            // a full spare always refills the head; ready is low then, so no accept competes
            h_valid_d = s_valid_q || accept;
            h_data_d  = s_valid_q ? s_data_q : (accept ? in_data : h_data_q);
            s_valid_d = 1'b0;
        end else if (accept) begin
            h_valid_d = 1'b1;
            h_data_d  = h_valid_q ? h_data_q : in_data;
            s_valid_d = h_valid_q;
            s_data_d  = h_valid_q ? in_data : s_data_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_data_q  <= '0;
            s_data_q  <= '0;
            h_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            h_data_q  <= h_data_d;
            s_data_q  <= s_data_d;
            h_valid_q <= h_valid_d;
            s_valid_q <= s_valid_d;
            ready_q   <= !s_valid_d;
        end
    end
    assign in_ready  = ready_q;
    assign out_data  = h_data_q;
    assign out_valid = h_valid_q;
endmodule

// File: rtl/stream_xbar_demux.sv
// stream_xbar_demux: steers each packet of one crossbar output back to its source stream,
// locking the id per packet and dropping (and counting) beats whose id strays mid-packet.
module stream_xbar_demux
    import stream_xbar_pkg::*;
#(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 2
) (
    input logic clk,
    input logic rst_n,
    stream_xbar_demux_if.slave bus
);
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);
    localparam int W = T_ID___WIDTH + 1 + T_DATA_WIDTH;
    logic [W-1:0]              h_pl;
    logic [T_ID___WIDTH-1:0]   h_id, cur_id_q, cur_id_d;
    logic [T_DATA_WIDTH-1:0]   h_data;
    logic                      h_last, h_valid, oor, drop, route, pop, err_q, err_d;
    logic [DROP_CNT_WIDTH-1:0] cnt_q, cnt_d;
    demux_state_t              state_q, state_d;
    assign {h_id, h_last, h_data} = h_pl;
    stream_skid_buf #(.W(W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  ({bus.s_id_i, bus.s_last_i, bus.s_data_i}),
        .in_valid (bus.s_valid_i),
        .in_ready (bus.s_ready_o),
        .out_data (h_pl),
        .out_valid(h_valid),
        .out_pop  (pop)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cur_id_q <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        if (pop && route) begin
            if (state_q == IDLE && !h_last) begin
                state_d  = PKT;
                cur_id_d = h_id;
            end else if (state_q == PKT && h_last) begin
                state_d = IDLE;
            end
        end
        err_d = err_q || drop;
        cnt_d = (drop && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    // in PKT a routed beat has h_id == cur_id, so h_id is the select in every state
    always_comb begin
        oor  = 32'(h_id) >= S_DATA_COUNT;
        drop = h_valid && (oor || (state_q == PKT && h_id != cur_id_q));
        route = h_valid && !drop;
        bus.m_valid_o = '0;
        for (int k = 0; k < S_DATA_COUNT; k++)
            bus.m_valid_o[k] = route && h_id == T_ID___WIDTH'(k);
        pop = drop || (route && bus.m_ready_i[h_id]);
    end
    for (genvar g = 0; g < S_DATA_COUNT; g++) begin : g_out
        assign bus.m_data_o[g] = h_data;
    end
    assign bus.m_last_o   = {S_DATA_COUNT{h_last}};
    assign bus.err_o      = err_q;
    assign bus.drop_cnt_o = cnt_q;
endmodule

// File: tb/tb_stream_xbar_demux.sv
// tb_stream_xbar_demux: directed and random stimulus checked against a packet-level reference model.
module tb_stream_xbar_demux;
    localparam int DW = 8;
    localparam int SC = 2;
    localparam int IW = $clog2(SC);
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    stream_xbar_demux_if #(.T_DATA_WIDTH(DW), .S_DATA_COUNT(SC)) bus ();
    stream_xbar_demux #(.T_DATA_WIDTH(DW), .S_DATA_COUNT(SC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    typedef struct {
        bit       dlv;
        int       k;
        logic [7:0] d;
        bit       l;
    } ent_t;
    ent_t q[$];
    ent_t e;
    bit   m_pkt;
    int   m_lock;
    int   exp_drops;
    int   rx_cnt[SC];
    logic [SC-1:0] pv, pr;
    logic [DW-1:0] pd[SC];
    logic [SC-1:0] pl;
    function automatic int sat(input int n);
        return n > 255 ? 255 : n;
    endfunction
    // reference model: every accepted beat is classified at packet level, then matched in order
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_pkt = 0;
            m_lock = 0;
            exp_drops = 0;
            pv = '0;
            pr = '0;
        end else begin
            chk("onehot_valid", 32'($countones(bus.m_valid_o) <= 1), 1);
            for (int k = 0; k < SC; k++) begin
                if (pv[k] && !pr[k]) begin
                    chk("hold_valid", bus.m_valid_o[k], 1);
                    chk("hold_data", bus.m_data_o[k], pd[k]);
                    chk("hold_last", bus.m_last_o[k], pl[k]);
                end
                if (bus.m_valid_o[k] && bus.m_ready_i[k]) begin
                    while (q.size() > 0 && !q[0].dlv) begin
                        void'(q.pop_front());
                        exp_drops++;
                    end
                    chk("beat_expected", 32'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        chk("rx_stream", k, e.k);
                        chk("rx_data", bus.m_data_o[k], e.d);
                        chk("rx_last", bus.m_last_o[k], e.l);
                    end
                    rx_cnt[k]++;
                    chk("rx_drop_cnt", bus.drop_cnt_o, sat(exp_drops));
                    chk("rx_err", bus.err_o, exp_drops != 0);
                end
                pd[k] = bus.m_data_o[k];
            end
            pv = bus.m_valid_o;
            pr = bus.m_ready_i;
            pl = bus.m_last_o;
            if (bus.s_valid_i && bus.s_ready_o) begin
                e.d = bus.s_data_i;
                e.l = bus.s_last_i;
                e.k = int'(bus.s_id_i);
                e.dlv = !(e.k >= SC || (m_pkt && e.k != m_lock));
                if (e.dlv && !m_pkt && !e.l) begin
                    m_pkt = 1;
                    m_lock = e.k;
                end else if (e.dlv && m_pkt && e.l) begin
                    m_pkt = 0;
                end
                q.push_back(e);
            end
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] d, input int id, input bit l);
        bit ok = 0;
        bus.s_data_i = d;
        bus.s_id_i = IW'(id);
        bus.s_last_i = l;
        bus.s_valid_i = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.s_ready_o;
        end
        chk("send_accepted", 32'(ok), 1);
        tick();
        bus.s_valid_i = 1'b0;
    endtask
    task automatic drain(input string name);
        bus.m_ready_i = '1;
        bus.s_valid_i = 1'b0;
        repeat (8) tick();
        while (q.size() > 0 && !q[0].dlv) begin
            void'(q.pop_front());
            exp_drops++;
        end
        chk({name, "_queue_empty"}, q.size(), 0);
        chk({name, "_drop_cnt"}, bus.drop_cnt_o, sat(exp_drops));
        chk({name, "_err"}, bus.err_o, exp_drops != 0);
    endtask
    task automatic reset_outputs(input string name);
        chk({name, "_s_ready"}, bus.s_ready_o, 0);
        chk({name, "_m_valid"}, bus.m_valid_o, 0);
        chk({name, "_err"}, bus.err_o, 0);
        chk({name, "_drop_cnt"}, bus.drop_cnt_o, 0);
        chk({name, "_m_data0"}, bus.m_data_o[0], 0);
        chk({name, "_m_data1"}, bus.m_data_o[1], 0);
        chk({name, "_m_last"}, bus.m_last_o, 0);
    endtask
    logic [SC-1:0] seq[4];
    int r0, r1, n, rid;
    bit acc;
    initial begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i = '0;
        bus.s_id_i = '0;
        bus.s_last_i = 1'b0;
        bus.m_ready_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", bus.s_ready_o, 0);
        @(negedge clk);
        chk("ready_after_edge", bus.s_ready_o, 1);
        tick();
        // single-beat packet
        bus.m_ready_i = 2'b11;
        send(8'hA5, 1, 1);
        @(negedge clk);
        chk("single_valid", bus.m_valid_o, 2'b10);
        chk("single_data", bus.m_data_o[1], 8'hA5);
        chk("single_last", bus.m_last_o[1], 1);
        tick();
        // back-to-back packets, one beat per cycle
        for (int i = 0; i < 4; i++) begin
            bus.s_data_i = 8'(i < 2 ? 8'h20 + i : 8'h30 + i - 2);
            bus.s_id_i = IW'(i / 2);
            bus.s_last_i = i[0];
            bus.s_valid_i = 1'b1;
            @(negedge clk);
            chk("b2b_ready", bus.s_ready_o, 1);
            if (i > 0) seq[i-1] = bus.m_valid_o;
            tick();
        end
        bus.s_valid_i = 1'b0;
        @(negedge clk);
        seq[3] = bus.m_valid_o;
        chk("b2b_seq0", seq[0], 2'b01);
        chk("b2b_seq1", seq[1], 2'b01);
        chk("b2b_seq2", seq[2], 2'b10);
        chk("b2b_seq3", seq[3], 2'b10);
        tick();
        // backpressure on stream 0
        r0 = rx_cnt[0];
        bus.m_ready_i = 2'b00;
        send(8'h10, 0, 0);
        send(8'h11, 0, 0);
        @(negedge clk);
        chk("bp_ready_low", bus.s_ready_o, 0);
        chk("bp_valid", bus.m_valid_o, 2'b01);
        chk("bp_data", bus.m_data_o[0], 8'h10);
        tick();
        @(negedge clk);
        chk("bp_still_low", bus.s_ready_o, 0);
        tick();
        bus.m_ready_i = 2'b01;
        send(8'h12, 0, 0);
        send(8'h13, 0, 1);
        drain("bp");
        chk("bp_rx_count", rx_cnt[0] - r0, 4);
        // mid-packet id change
        r0 = rx_cnt[0];
        r1 = rx_cnt[1];
        send(8'h00, 0, 0);
        send(8'h01, 0, 0);
        send(8'h02, 1, 0);
        send(8'h03, 0, 1);
        drain("mid");
        chk("mid_err", bus.err_o, 1);
        chk("mid_drop_cnt", bus.drop_cnt_o, 1);
        chk("mid_model_drops", exp_drops, 1);
        chk("mid_rx0", rx_cnt[0] - r0, 3);
        chk("mid_rx1", rx_cnt[1] - r1, 0);
        // reset mid-packet with beats still buffered
        bus.m_ready_i = 2'b00;
        send(8'h40, 0, 0);
        send(8'h41, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        bus.m_ready_i = 2'b11;
        send(8'h5A, 1, 1);
        @(negedge clk);
        chk("postrst_valid", bus.m_valid_o, 2'b10);
        chk("postrst_data", bus.m_data_o[1], 8'h5A);
        tick();
        // drop counter saturation
        send(8'h60, 0, 0);
        n = 0;
        bus.s_id_i = IW'(1);
        bus.s_valid_i = 1'b1;
        for (int i = 0; i < 1000 && n < 300; i++) begin
            bus.s_data_i = 8'(i);
            bus.s_last_i = (i % 7) == 0;
            @(negedge clk);
            if (bus.s_ready_o) n++;
            tick();
        end
        drain("sat");
        chk("sat_drop_cnt", bus.drop_cnt_o, 255);
        chk("sat_err", bus.err_o, 1);
        chk("sat_model_drops", exp_drops, 300);
        r0 = rx_cnt[0];
        send(8'h61, 0, 1);
        drain("sat_end");
        chk("sat_end_rx0", rx_cnt[0] - r0, 1);
        // randomized traffic from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rid = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            acc = bus.s_valid_i && bus.s_ready_o;
            tick();
            if (!bus.s_valid_i || acc) begin
                if ($urandom_range(0, 99) < 15) rid = $urandom_range(0, SC - 1);
                bus.s_valid_i = $urandom_range(0, 1) == 1;
                bus.s_id_i = IW'(rid);
                bus.s_data_i = 8'($urandom);
                bus.s_last_i = $urandom_range(0, 99) < 30;
            end
            for (int k = 0; k < SC; k++) bus.m_ready_i[k] = $urandom_range(0, 99) < 70;
        end
        drain("rand");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
